// File: rtl/bram_pingpong_counter_if.sv
// Sample-capture control bundle between a receiver/host and the ping-pong BRAM address generator.
// master drives strobes and host acks; slave returns the BRAM write port and status.
interface bram_pingpong_counter_if #(
  parameter int ADDR_W = 32
);
  logic              hab;
  logic              valid;
  logic              start;
  logic              clr;
  logic              ack;
  logic              enable;
  logic [ADDR_W-1:0] addr;
  logic              done;
  logic              done_bank;
  logic              overrun;
  logic [15:0]       ovr_cnt;

  modport master (
    output hab, valid, start, clr, ack,
    input  enable, addr, done, done_bank, overrun, ovr_cnt
  );

  modport slave (
    input  hab, valid, start, clr, ack,
    output enable, addr, done, done_bank, overrun, ovr_cnt
  );
endinterface

// File: rtl/bram_pingpong_counter.sv
// Ping-pong BRAM write-address generator: two DEPTH-sample banks, host acks a drained bank.
// Latency 1 cycle (enable/addr/done registered); no backpressure, samples in STALL are dropped and flagged.
// OVERRUN_COUNT_EN adds a saturating 16-bit drop counter; otherwise ovr_cnt is tied to zero.
module bram_pingpong_counter #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int STEP   = 4,
  parameter int BASE   = 0
) (
  input logic                   clk,
  input logic                   rst,
  bram_pingpong_counter_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t            state_q, state_d;
  logic              bank_q, bank_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        full_q, full_d;
  logic              enable_q, enable_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              done_bank_q, done_bank_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] wr_addr;

  // {bank, idx} equals bank*DEPTH + idx because DEPTH is a power of two
  assign wr_addr = BASE_ADDR + ADDR_W'({bank_q, idx_q}) * ADDR_W'(STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      idx_q       <= '0;
      full_q      <= 2'b00;
      enable_q    <= 1'b0;
      addr_q      <= BASE_ADDR;
      done_q      <= 1'b0;
      done_bank_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      idx_q       <= idx_d;
      full_q      <= full_d;
      enable_q    <= enable_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      done_bank_q <= done_bank_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    idx_d       = idx_q;
    full_d      = full_q;
    enable_d    = 1'b0;
    addr_d      = addr_q;
    done_d      = 1'b0;
    done_bank_d = done_bank_q;
    overrun_d   = overrun_q;

    if (bus.clr) begin
      state_d     = IDLE;
      bank_d      = 1'b0;
      idx_d       = '0;
      full_d      = 2'b00;
      addr_d      = BASE_ADDR;
      done_bank_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      // host release is applied before the fill decision so a coincident ack avoids STALL
      if (bus.ack) begin
        full_d[~bank_q] = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            bank_d  = 1'b0;
            idx_d   = '0;
          end
        end
        RUN: begin
          if (bus.hab && bus.valid) begin
            enable_d = 1'b1;
            addr_d   = wr_addr;
            idx_d    = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              full_d[bank_q] = 1'b1;
              done_d         = 1'b1;
              done_bank_d    = bank_q;
              if (!full_d[~bank_q]) begin
                bank_d = ~bank_q;
              end else begin
                state_d = STALL;
              end
            end
          end
        end
        STALL: begin
          if (bus.hab && bus.valid) begin
            overrun_d = 1'b1;
          end
          // resume once the other bank is free; an ack seen while hab is low is honoured later
          if (bus.hab && !full_d[~bank_q]) begin
            bank_d  = ~bank_q;
            idx_d   = '0;
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.enable    = enable_q;
  assign bus.addr      = addr_q;
  assign bus.done      = done_q;
  assign bus.done_bank = done_bank_q;
  assign bus.overrun   = overrun_q;

`ifdef OVERRUN_COUNT_EN
  logic        drop;
  logic [15:0] ovr_cnt_q;

  assign drop = (state_q == STALL) && bus.hab && bus.valid && !bus.clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_cnt_q <= 16'h0000;
    end else if (bus.clr) begin
      ovr_cnt_q <= 16'h0000;
    end else if (drop && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 16'h0001;
    end
  end

  assign bus.ovr_cnt = ovr_cnt_q;
`else
  assign bus.ovr_cnt = 16'h0000;
`endif

endmodule
